memory_ram_param: RTL
=====================

// Module: memory_ram_param
// PURPOSE
//   Parametrised single-port synchronous RAM; next generation of the 16x16 lab RAM.
//   - Adds byte-lane write enables, a read-valid strobe and a selectable read-during-write mode.
//   - Adds a hardware clear sequencer that zeroes the whole array.
//   - Serves as the general storage primitive for register files and buffers in lab designs.
// PARAMETERS
//   DATA_W       16   word width in bits; must be a multiple of 8
//   ADDR_W       4    address width; DEPTH = 2**ADDR_W words
//   WRITE_FIRST  0    0: a write leaves out unchanged; 1: a write also drives the written word to out
// PORTS
//   clk        in   1          rising-edge clock
//   rst        in   1          synchronous, active-high reset
//   en         in   1          access enable
//   wen        in   1          1 = write, 0 = read (qualified by en)
//   be         in   DATA_W/8   byte-lane write enables; be[i] covers din[8i+7:8i]
//   address    in   ADDR_W     word address
//   din        in   DATA_W     write data
//   clr        in   1          one-cycle pulse; starts the clear sweep
//   out        out  DATA_W     read data, registered
//   out_valid  out  1          one-cycle strobe marking new data on out
//   busy       out  1          clear sweep in progress; accesses are ignored
// BEHAVIOUR
//   Reset:
//   - Next edge with rst=1 sets: out=0, out_valid=0, busy=0, FSM=IDLE, clear counter=0.
//   - Array contents are NOT reset.
//   FSM states: IDLE, CLEAR.
//   - IDLE -> CLEAR on clr=1.
//   - CLEAR -> IDLE after the write to address DEPTH-1.
//   - rst returns to IDLE from any state.
//   Read (IDLE, en=1, wen=0):
//   - out <= mem[address] at the next edge; out_valid=1 for exactly that cycle.
//   - Latency is 1 cycle.
//   - out holds its last value when no read occurs; out_valid=0 otherwise.
//   Write (IDLE, en=1, wen=1):
//   - For each i with be[i]=1, mem[address][8i+7:8i] <= din[8i+7:8i]; other lanes are kept.
//   - be=0 makes the write a no-op.
//   - WRITE_FIRST=0: out and out_valid behave as on an idle cycle.
//   - WRITE_FIRST=1: out <= merged new word; out_valid=1 for one cycle.
//   Clear sweep:
//   - clr in IDLE enters CLEAR on the next edge; busy=1 from that edge.
//   - Each CLEAR cycle writes 0 to mem[cnt] and increments cnt.
//   - A full sweep is exactly DEPTH cycles; busy falls on the edge after the cnt=DEPTH-1 write.
//   - Next access is accepted in the cycle busy=0.
//   - out is unchanged by the sweep; out_valid=0 throughout.
//   Boundary conditions:
//   - clr and en in the same IDLE cycle: clr wins and the access is dropped.
//   - en while busy=1: ignored, with no memory change and no out_valid.
//   - clr while busy=1: ignored; the sweep is not restarted.
//   - rst mid-sweep: aborts the sweep immediately; the array is left partially cleared (addresses < cnt are zero).
//   - address is ADDR_W bits, so there is no out-of-range case; cnt wraps DEPTH-1 -> 0 on exit.
// CONFIGURATION
//   MEM_RAM_OUT_REG_EN defined:
//   - Adds one output pipeline stage after the array read.
//   - out and out_valid are delayed together by one cycle; read latency = 2.
//   - The stage resets to 0 / valid 0 with rst.
//   - The WRITE_FIRST data path also passes through the stage.
//   MEM_RAM_OUT_REG_EN undefined:
//   - Read latency = 1, as specified above.
// TESTING (DATA_W=16, ADDR_W=4, macro undefined unless stated)
//   1. Write 0xABCD to addr 3 (be=2'b11), then read addr 3 -> out=0xABCD one cycle after the read; out_valid high exactly 1 cycle.
//   2. Over 0xABCD at addr 3, write din=0x1234 with be=2'b01, then read -> out=0xAB34.
//   3. Fill all 16 addresses, pulse clr -> busy high exactly 16 cycles; en pulses during busy have no effect; reads of addr 0 and 15 return 0x0000.
//   4. Start a sweep, assert rst after 5 CLEAR cycles -> busy=0, out=0; addr 0-4 read 0, addr 5-15 keep old data.
//   5. WRITE_FIRST=1: write 0x5A5A to addr 7 -> out=0x5A5A and out_valid=1 the next cycle. WRITE_FIRST=0: out unchanged, out_valid=0.
//   6. With MEM_RAM_OUT_REG_EN defined, repeat test 1 -> out=0xABCD and out_valid arrive 2 cycles after the read; back-to-back reads stream one word per cycle.

Source files
------------

// File: rtl/memory_ram_param_if.sv
// memory_ram_param_if: access, clear and read-back signals of the parametrised single-port RAM.
// The master drives accesses and clear; the slave returns registered data, valid strobe and busy.
interface memory_ram_param_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
);
   logic                  en;
   logic                  wen;
   logic [DATA_W/8-1:0]   be;
   logic [ADDR_W-1:0]     address;
   logic [DATA_W-1:0]     din;
   logic                  clr;
   logic [DATA_W-1:0]     out;
   logic                  out_valid;
   logic                  busy;

   modport master (
      output en, wen, be, address, din, clr,
      input  out, out_valid, busy
   );

   modport slave (
      input  en, wen, be, address, din, clr,
      output out, out_valid, busy
   );
endinterface

// File: rtl/memory_ram_param.sv
// memory_ram_param: single-port RAM with byte enables and clear sweep; read latency 1, or 2 with MEM_RAM_OUT_REG_EN.
// No backpressure: any access presented while busy (or alongside clr) is silently dropped.
module memory_ram_param #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 4,
   parameter int WRITE_FIRST = 0
) (
   input logic               clk,
   input logic               rst,
   memory_ram_param_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam int LANES = DATA_W / 8;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] merged;
   logic [DATA_W-1:0] rd_dat;
   logic              rd_vld;
   logic              busy_q;
   logic              acc;

   // clr has priority over a same-cycle access
   assign acc = (state == IDLE) && !bus.clr && bus.en;

   always_comb begin
      merged = mem[bus.address];
      for (int i = 0; i < LANES; i++) begin
         if (bus.be[i]) merged[8*i +: 8] = bus.din[8*i +: 8];
      end
   end

   // array is never reset; rst only stops any write on its edge
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CLEAR)
            mem[cnt] <= '0;
         else if (acc && bus.wen)
            mem[bus.address] <= merged;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         rd_dat <= '0;
         rd_vld <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         rd_vld <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.clr) begin
                  state  <= CLEAR;
                  busy_q <= 1'b1;
               end else if (acc && !bus.wen) begin
                  rd_dat <= mem[bus.address];
                  rd_vld <= 1'b1;
               end else if (acc && (WRITE_FIRST != 0)) begin
                  rd_dat <= merged;
                  rd_vld <= 1'b1;
               end
            end
            CLEAR: begin
               cnt <= cnt + 1'b1;
               if (cnt == {ADDR_W{1'b1}}) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = busy_q;

`ifdef MEM_RAM_OUT_REG_EN
   logic [DATA_W-1:0] out_q;
   logic              vld_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q <= '0;
         vld_q <= 1'b0;
      end else begin
         vld_q <= rd_vld;
         if (rd_vld) out_q <= rd_dat;
      end
   end

   assign bus.out       = out_q;
   assign bus.out_valid = vld_q;
`else
   assign bus.out       = rd_dat;
   assign bus.out_valid = rd_vld;
`endif
endmodule
